dm_port_arbiter: RTL

- Shares the single-port byte-addressed data memory (DM) between two requesters: the CPU MEM stage and a word-only debug/loader port.
- Arbitrates access, checks CPU alignment, and encodes access size/sign into the DM control codes.
- Pipelines each access (accept → DM cycle → response) so one access can issue per cycle.
- Sits between the MEM stage / debug bridge and DM.

---
 rtl/dm_port_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares one single-port, byte-addressed data memory between the CPU MEM
//   stage and a word-only debug/loader port. Each access goes through a
//   two-register pipeline:
//     cycle N   : arbitration, grant is combinational on the req inputs
//     cycle N+1 : stage 1 registers drive the DM (address, codes, data, we)
//     cycle N+2 : stage 2 registers present the load result or the
//                 misalignment pulse
//   A new access can be granted every cycle.
//
// Handshake: a requester holds *_req with its command fields stable. The
//   command is taken in any cycle where *_req and *_gnt are both high.
//   Nothing is stored for a request that is not granted. The requester
//   re-presents it in a later cycle. Responses are single-cycle pulses
//   (*_rvalid, cpu_adel, cpu_ades) with no back-pressure.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/size/unsigned/addr/wdata   CPU command
//   cpu_gnt, cpu_stall             CPU accept / stall
//   cpu_rvalid, cpu_rdata          CPU load response
//   cpu_adel, cpu_ades             CPU misaligned load / store pulses
//   dbg_req/we/addr/wdata          debug word command
//   dbg_gnt, dbg_rvalid, dbg_rdata debug accept / read response
//   dm_we, dm_din_store, dm_dout_load, dm_addr, dm_d_in   DM drive
//   dm_d_out                       DM combinational read data
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_adel,
  output logic              cpu_ades,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dm_we,
  output logic [1:0]        dm_din_store,
  output logic [2:0]        dm_dout_load,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_d_in,
  input  logic [DATA_W-1:0] dm_d_out
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] starve_cnt;
  logic             dbg_win;

  // Debug normally yields to the CPU. Once it has been denied STARVE_MAX
  // cycles in a row, it takes the slot even against a CPU request.
  assign dbg_win   = dbg_req & (~cpu_req | (starve_cnt == STARVE_LIM));
  assign dbg_gnt   = ~reset & dbg_win;
  assign cpu_gnt   = ~reset & cpu_req & ~dbg_win;
  assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (dbg_req & ~dbg_gnt) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // CPU command decode (size 11 behaves as word)
  // ---------------------------------------------------------------------
  logic [1:0] cpu_size_n;
  logic       cpu_mis;

  assign cpu_size_n = (cpu_size == 2'b11) ? 2'b00 : cpu_size;
  assign cpu_mis    = ((cpu_size_n == 2'b00) & (cpu_addr[1:0] != 2'b00)) |
                      ((cpu_size_n == 2'b01) & cpu_addr[0]);

  // ---------------------------------------------------------------------
  // Stage 1: granted command, drives the DM during cycle N+1.
  // Fields are cleared when no grant happens, so an idle stage drives zeros.
  // ---------------------------------------------------------------------
  logic              s1_valid;
  logic              s1_dbg;
  logic              s1_we;
  logic [1:0]        s1_size;
  logic              s1_uns;
  logic              s1_mis;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_dbg   <= 1'b0;
      s1_we    <= 1'b0;
      s1_size  <= 2'b00;
      s1_uns   <= 1'b0;
      s1_mis   <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
    end else if (dbg_gnt) begin
      s1_valid <= 1'b1;
      s1_dbg   <= 1'b1;
      s1_we    <= dbg_we;
      s1_size  <= 2'b00;
      s1_uns   <= 1'b0;
      s1_mis   <= 1'b0;
      s1_addr  <= dbg_addr & WORD_MASK;
      s1_wdata <= dbg_wdata;
    end else if (cpu_gnt) begin
      s1_valid <= 1'b1;
      s1_dbg   <= 1'b0;
      s1_we    <= cpu_we;
      s1_size  <= cpu_size_n;
      s1_uns   <= cpu_unsigned;
      s1_mis   <= cpu_mis;
      s1_addr  <= cpu_addr;
      s1_wdata <= cpu_wdata;
    end else begin
      s1_valid <= 1'b0;
      s1_dbg   <= 1'b0;
      s1_we    <= 1'b0;
      s1_size  <= 2'b00;
      s1_uns   <= 1'b0;
      s1_mis   <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
    end
  end

  // Read code: word 000, half 001/011, byte 010/100 (signed/unsigned).
  logic [2:0] load_code;

  always_comb begin
    load_code = 3'b000;
    case (s1_size)
      2'b01:   load_code = s1_uns ? 3'b011 : 3'b001;
      2'b10:   load_code = s1_uns ? 3'b100 : 3'b010;
      default: load_code = 3'b000;
    endcase
  end

  // A misaligned access keeps its slot but never writes the DM.
  assign dm_we        = s1_we & ~s1_mis;
  assign dm_addr      = s1_addr;
  assign dm_d_in      = s1_wdata;
  assign dm_din_store = s1_size;
  assign dm_dout_load = s1_we ? {1'b0, s1_size} : load_code;

  // ---------------------------------------------------------------------
  // Stage 2: response pulses in cycle N+2; rdata holds between responses.
  // ---------------------------------------------------------------------
  logic s1_load_ok;
  assign s1_load_ok = s1_valid & ~s1_we & ~s1_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_adel   <= 1'b0;
      cpu_ades   <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= s1_load_ok & ~s1_dbg;
      dbg_rvalid <= s1_load_ok & s1_dbg;
      cpu_adel   <= s1_valid & ~s1_dbg & ~s1_we & s1_mis;
      cpu_ades   <= s1_valid & ~s1_dbg & s1_we & s1_mis;
      if (s1_load_ok & ~s1_dbg) cpu_rdata <= dm_d_out;
      if (s1_load_ok & s1_dbg)  dbg_rdata <= dm_d_out;
    end
  end

endmodule
